// File: rtl/fuse_ctrl_filter_pkg.sv
// Shared types, constants and the partition address map for the fuse-controller DAI access filter.
package fuse_ctrl_filter_pkg;

  localparam int NumParts      = 16;
  localparam int AddrWidth     = 32;
  localparam int UserWidth     = 32;
  localparam int OtpAddrWidth  = 12;
  localparam int CntWidth      = 11;
  localparam int PartIdxWidth  = $clog2(NumParts);
  localparam int TimeoutCycles = 1024;

  localparam logic [7:0] DaiAddrOffset = 8'h60;
  localparam logic [7:0] DaiCmdOffset  = 8'h64;

  localparam int CmdWrBit     = 1;
  localparam int CmdDigestBit = 2;

  // Life-cycle multi-bit signal; any value other than Off counts as escalation.
  typedef logic [3:0] lc_tx_t;
  localparam lc_tx_t LcTxOff = 4'b1010;

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StPass,
    StDiscard,
    StLocked
  } filter_state_e;

  typedef struct packed {
    logic [OtpAddrWidth-1:0] base;
    logic [OtpAddrWidth-1:0] size;
  } part_range_t;

  // Fuse map mirrored from the otp_ctrl partition offsets; 0x700 and up belongs to no partition.
  localparam part_range_t PartRange [NumParts] = '{
    '{12'h000, 12'h040}, '{12'h040, 12'h060}, '{12'h0A0, 12'h040}, '{12'h0E0, 12'h080},
    '{12'h160, 12'h080}, '{12'h1E0, 12'h040}, '{12'h220, 12'h040}, '{12'h260, 12'h0C0},
    '{12'h320, 12'h0C0}, '{12'h3E0, 12'h060}, '{12'h440, 12'h060}, '{12'h4A0, 12'h040},
    '{12'h4E0, 12'h100}, '{12'h5E0, 12'h0A0}, '{12'h680, 12'h040}, '{12'h6C0, 12'h040}
  };

endpackage

// File: rtl/fuse_ctrl_filter_range_match.sv
// Combinational fuse address -> partition lookup over the package range table.
module fuse_ctrl_filter_range_match
  import fuse_ctrl_filter_pkg::*;
(
  input  logic [OtpAddrWidth-1:0] addr_i,
  output logic                    hit_o,
  output logic [PartIdxWidth-1:0] idx_o
);

  // Compare at one extra bit so base+size of the top partition cannot wrap.
  logic [OtpAddrWidth:0] addr_ext;
  assign addr_ext = {1'b0, addr_i};

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NumParts - 1; i >= 0; i--) begin
      if (addr_ext >= {1'b0, PartRange[i].base} &&
          addr_ext <  ({1'b0, PartRange[i].base} + {1'b0, PartRange[i].size})) begin
        hit_o = 1'b1;
        idx_o = PartIdxWidth'(i);
      end
    end
  end

endmodule

// File: rtl/fuse_ctrl_access_filter.sv
// Snoops DAI address/command writes and forces AccessError on unauthorised partition programming.
// Optional error log outputs are built when FUSE_CTRL_FILTER_ERR_LOG_EN is defined.
module fuse_ctrl_access_filter
  import fuse_ctrl_filter_pkg::*;
(
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                wr_valid_i,
  input  logic                                wr_ready_i,
  input  logic [AddrWidth-1:0]                wr_addr_i,
  input  logic [31:0]                         wr_data_i,
  input  logic [UserWidth-1:0]                wr_user_i,
  input  logic [NumParts-1:0][UserWidth-1:0]  part_user_i,
  input  lc_tx_t                              lc_escalate_en_i,
  input  logic                                dai_idle_i,
  output logic                                discard_fuse_write_o,
  output logic                                filter_busy_o
`ifdef FUSE_CTRL_FILTER_ERR_LOG_EN
  ,
  output logic [7:0]                          viol_cnt_o,
  output logic [OtpAddrWidth-1:0]             last_viol_addr_o,
  output logic [UserWidth-1:0]                last_viol_user_o
`endif
);

  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

  filter_state_e           state_q, state_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic                    started_q, started_d;
  logic                    discard_q, discard_d;
  logic [OtpAddrWidth-1:0] addr_q, addr_d;
  logic [UserWidth-1:0]    user_q, user_d;
  logic                    addr_vld_q, addr_vld_d;

  logic accepted, addr_wr, cmd_wr, escalate, cmd_eval, viol;
  logic                    hit;
  logic [PartIdxWidth-1:0] hit_idx;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{wr_addr_i[AddrWidth-1:8], wr_data_i[31:OtpAddrWidth]};

  assign accepted = wr_valid_i && wr_ready_i;
  assign addr_wr  = accepted && (wr_addr_i[7:0] == DaiAddrOffset);
  assign cmd_wr   = accepted && (wr_addr_i[7:0] == DaiCmdOffset);
  assign escalate = (lc_escalate_en_i != LcTxOff);
  assign cmd_eval = cmd_wr && (wr_data_i[CmdWrBit] || wr_data_i[CmdDigestBit]) &&
                    (state_q == StIdle) && !escalate;

  fuse_ctrl_filter_range_match u_range_match (
    .addr_i (addr_q),
    .hit_o  (hit),
    .idx_o  (hit_idx)
  );

  assign viol = !addr_vld_q || (wr_user_i != user_q) || !hit || (user_q != part_user_i[hit_idx]);

  always_comb begin
    addr_d     = addr_q;
    user_d     = user_q;
    addr_vld_d = addr_vld_q;
    if (addr_wr) begin
      addr_d     = wr_data_i[OtpAddrWidth-1:0];
      user_d     = wr_user_i;
      addr_vld_d = 1'b1;
    end else if (cmd_eval) begin
      addr_vld_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    started_d = started_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_eval) state_d = viol ? StDiscard : StPass;
      end
      StPass, StDiscard: begin
        started_d = started_q || !dai_idle_i;
        if ((started_q && dai_idle_i) || (cnt_q == TimeoutLast)) state_d = StIdle;
      end
      StLocked: state_d = StLocked;
      // StWaitStart is a reserved encoding and is never entered.
      default:  state_d = StIdle;
    endcase
    if (escalate) state_d = StLocked;

    if (state_d != state_q) begin
      cnt_d     = '0;
      started_d = 1'b0;
    end else begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
    discard_d = (state_d == StDiscard) || (state_d == StLocked);
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      started_q  <= 1'b0;
      discard_q  <= 1'b0;
      addr_q     <= '0;
      user_q     <= '0;
      addr_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      started_q  <= started_d;
      discard_q  <= discard_d;
      addr_q     <= addr_d;
      user_q     <= user_d;
      addr_vld_q <= addr_vld_d;
    end
  end

  assign discard_fuse_write_o = discard_q;
  assign filter_busy_o        = (state_q != StIdle);

`ifdef FUSE_CTRL_FILTER_ERR_LOG_EN
  logic [7:0]              viol_cnt_q;
  logic [OtpAddrWidth-1:0] last_viol_addr_q;
  logic [UserWidth-1:0]    last_viol_user_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      viol_cnt_q       <= '0;
      last_viol_addr_q <= '0;
      last_viol_user_q <= '0;
    end else if (cmd_eval && viol) begin
      viol_cnt_q       <= (viol_cnt_q == 8'hFF) ? viol_cnt_q : viol_cnt_q + 8'd1;
      last_viol_addr_q <= addr_q;
      last_viol_user_q <= wr_user_i;
    end
  end

  assign viol_cnt_o       = viol_cnt_q;
  assign last_viol_addr_o = last_viol_addr_q;
  assign last_viol_user_o = last_viol_user_q;
`endif

endmodule

// File: tb/tb_fuse_ctrl_access_filter.sv
// Self-checking bench: a transaction-level model predicts discard/busy every cycle, plus directed literal checks.
module tb_fuse_ctrl_access_filter;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               wr_valid_i = 1'b0;
  logic               wr_ready_i = 1'b0;
  logic [31:0]        wr_addr_i = '0;
  logic [31:0]        wr_data_i = '0;
  logic [31:0]        wr_user_i = '0;
  logic [15:0][31:0]  part_user_i;
  logic [3:0]         lc_escalate_en_i = 4'b1010;
  logic               dai_idle_i = 1'b1;
  logic               discard_fuse_write_o;
  logic               filter_busy_o;
`ifdef FUSE_CTRL_FILTER_ERR_LOG_EN
  logic [7:0]         viol_cnt_o;
  logic [11:0]        last_viol_addr_o;
  logic [31:0]        last_viol_user_o;
`endif

  localparam logic [3:0] LC_OFF = 4'b1010;
  localparam logic [3:0] LC_ON  = 4'b0101;

  fuse_ctrl_access_filter dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .wr_valid_i           (wr_valid_i),
    .wr_ready_i           (wr_ready_i),
    .wr_addr_i            (wr_addr_i),
    .wr_data_i            (wr_data_i),
    .wr_user_i            (wr_user_i),
    .part_user_i          (part_user_i),
    .lc_escalate_en_i     (lc_escalate_en_i),
    .dai_idle_i           (dai_idle_i),
    .discard_fuse_write_o (discard_fuse_write_o),
    .filter_busy_o        (filter_busy_o)
`ifdef FUSE_CTRL_FILTER_ERR_LOG_EN
    ,
    .viol_cnt_o           (viol_cnt_o),
    .last_viol_addr_o     (last_viol_addr_o),
    .last_viol_user_o     (last_viol_user_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fuse map as exclusive upper limits of back-to-back partitions starting at 0.
  int part_limit [16] = '{'h040, 'h0A0, 'h0E0, 'h160, 'h1E0, 'h220, 'h260, 'h320,
                          'h3E0, 'h440, 'h4A0, 'h4E0, 'h5E0, 'h680, 'h6C0, 'h700};

  function automatic int part_of(input int a);
    for (int i = 0; i < 16; i++) if (a < part_limit[i]) return i;
    return -1;
  endfunction

  typedef enum int {M_IDLE, M_PASS, M_DISCARD, M_LOCKED} mdl_kind_e;
  mdl_kind_e   m_kind = M_IDLE;
  bit          m_vld = 1'b0;
  int          m_addr = 0;
  logic [31:0] m_user = '0;
  int          m_age = 0;
  bit          m_seen_low = 1'b0;
  int          m_viol = 0;
  int          m_last_addr = 0;
  logic [31:0] m_last_user = '0;

  function automatic bit model_allows(input logic [31:0] cmd_user);
    int p;
    p = part_of(m_addr);
    if (!m_vld || cmd_user != m_user || p < 0) return 1'b0;
    return (m_user == part_user_i[p]);
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_kind = M_IDLE; m_vld = 1'b0; m_addr = 0; m_user = '0; m_age = 0; m_seen_low = 1'b0;
      m_viol = 0; m_last_addr = 0; m_last_user = '0;
    end else begin
      bit acc, is_addr, is_prog;
      acc     = wr_valid_i && wr_ready_i;
      is_addr = acc && wr_addr_i[7:0] == 8'h60;
      is_prog = acc && wr_addr_i[7:0] == 8'h64 && (wr_data_i[1] || wr_data_i[2]);
      if (lc_escalate_en_i != LC_OFF) begin
        m_kind = M_LOCKED;
      end else if (m_kind == M_IDLE) begin
        if (is_prog) begin
          if (model_allows(wr_user_i)) m_kind = M_PASS;
          else begin
            m_kind = M_DISCARD;
            if (m_viol < 255) m_viol++;
            m_last_addr = m_addr;
            m_last_user = wr_user_i;
          end
          m_vld = 1'b0; m_age = 0; m_seen_low = 1'b0;
        end
      end else if (m_kind == M_PASS || m_kind == M_DISCARD) begin
        m_age++;
        if ((m_seen_low && dai_idle_i) || m_age >= 1024) m_kind = M_IDLE;
        else if (!dai_idle_i) m_seen_low = 1'b1;
      end
      if (is_addr) begin
        m_addr = int'(wr_data_i[11:0]); m_user = wr_user_i; m_vld = 1'b1;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("discard", {31'b0, discard_fuse_write_o}, {31'b0, (m_kind == M_DISCARD || m_kind == M_LOCKED)});
      check("busy", {31'b0, filter_busy_o}, {31'b0, (m_kind != M_IDLE)});
`ifdef FUSE_CTRL_FILTER_ERR_LOG_EN
      check("viol_cnt", {24'b0, viol_cnt_o}, m_viol);
      check("last_viol_addr", {20'b0, last_viol_addr_o}, m_last_addr);
      check("last_viol_user", last_viol_user_o, m_last_user);
`endif
    end
  end

  task automatic bus_wr(input logic [7:0] off, input logic [31:0] data, input logic [31:0] user,
                        input logic ready = 1'b1);
    @(posedge clk_i); #1;
    wr_valid_i = 1'b1; wr_ready_i = ready;
    wr_addr_i = {24'h0, off}; wr_data_i = data; wr_user_i = user;
    @(posedge clk_i); #1;
    wr_valid_i = 1'b0; wr_ready_i = 1'b0;
  endtask

  task automatic dai_cycle();
    dai_idle_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    dai_idle_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic lit(input string name, input logic disc, input logic busy);
    check({name, "_discard"}, {31'b0, discard_fuse_write_o}, {31'b0, disc});
    check({name, "_busy"}, {31'b0, filter_busy_o}, {31'b0, busy});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) part_user_i[i] = 32'hA;
    @(posedge clk_i); chk_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1; lit("reset", 1'b0, 1'b0);
    rst_ni = 1'b1;

    // Allowed write: partition 1 owned by 0xA.
    bus_wr(8'h60, 32'h040, 32'hA);
    bus_wr(8'h64, 32'h2, 32'hA);
    lit("pass", 1'b0, 1'b1);
    check("mdl_pass", int'(m_kind), int'(M_PASS));
    dai_cycle();
    lit("pass_done", 1'b0, 1'b0);

    // Owner mismatch.
    part_user_i[1] = 32'hB;
    bus_wr(8'h60, 32'h040, 32'hA);
    bus_wr(8'h64, 32'h2, 32'hA);
    lit("owner", 1'b1, 1'b1);
    check("mdl_discard", int'(m_kind), int'(M_DISCARD));
`ifdef FUSE_CTRL_FILTER_ERR_LOG_EN
    check("viol_cnt_first", {24'b0, viol_cnt_o}, 32'd1);
`endif
    dai_cycle();
    lit("owner_done", 1'b0, 1'b0);

    // Command issued by a different requester than the address.
    bus_wr(8'h60, 32'h100, 32'hA);
    bus_wr(8'h64, 32'h2, 32'hC);
    lit("user_swap", 1'b1, 1'b1);
    dai_cycle();

    // No address since the last evaluated command.
    bus_wr(8'h64, 32'h2, 32'hA);
    lit("no_addr", 1'b1, 1'b1);
    dai_cycle();

    // Range boundaries.
    bus_wr(8'h60, 32'hFFF, 32'hA); bus_wr(8'h64, 32'h2, 32'hA);
    lit("addr_fff", 1'b1, 1'b1); dai_cycle();
    bus_wr(8'h60, 32'h700, 32'hA); bus_wr(8'h64, 32'h2, 32'hA);
    lit("addr_700", 1'b1, 1'b1); dai_cycle();
    bus_wr(8'h60, 32'h6FF, 32'hA); bus_wr(8'h64, 32'h2, 32'hA);
    lit("addr_6ff", 1'b0, 1'b1); dai_cycle();
    bus_wr(8'h60, 32'h03F, 32'hA); bus_wr(8'h64, 32'h2, 32'hA);
    lit("addr_03f", 1'b0, 1'b1); dai_cycle();

    // Read command passes untouched and keeps the address valid for a later digest.
    bus_wr(8'h60, 32'h100, 32'hA);
    bus_wr(8'h64, 32'h1, 32'hA);
    lit("read_cmd", 1'b0, 1'b0);
    bus_wr(8'h64, 32'h4, 32'hA);
    lit("digest", 1'b0, 1'b1);
    dai_cycle();

    // Valid without ready is not an accepted beat.
    bus_wr(8'h60, 32'h100, 32'hA);
    bus_wr(8'h64, 32'h2, 32'hC, 1'b0);
    lit("no_ready", 1'b0, 1'b0);

    // Commands while busy are ignored; an address while busy is still latched.
    bus_wr(8'h64, 32'h2, 32'hA);
    lit("busy_pass", 1'b0, 1'b1);
    bus_wr(8'h60, 32'hFFF, 32'hA);
    bus_wr(8'h64, 32'h2, 32'hC);
    lit("busy_ignore", 1'b0, 1'b1);
    dai_cycle();
    bus_wr(8'h64, 32'h2, 32'hA);
    lit("addr_while_busy", 1'b1, 1'b1);
    dai_cycle();

    // Timeout with DAI never leaving idle.
    bus_wr(8'h60, 32'h100, 32'hA);
    bus_wr(8'h64, 32'h2, 32'hC);
    repeat (1023) begin @(posedge clk_i); #1; end
    lit("timeout_hold", 1'b1, 1'b1);
    @(posedge clk_i); #1;
    lit("timeout_exit", 1'b0, 1'b0);

    // Escalation mid-Pass locks permanently.
    bus_wr(8'h60, 32'h100, 32'hA);
    bus_wr(8'h64, 32'h2, 32'hA);
    lit("pre_esc", 1'b0, 1'b1);
    lc_escalate_en_i = LC_ON;
    @(posedge clk_i); #1;
    lit("locked", 1'b1, 1'b1);
    dai_cycle();
    lc_escalate_en_i = LC_OFF;
    repeat (3) begin @(posedge clk_i); #1; end
    lit("locked_hold", 1'b1, 1'b1);
    check("mdl_locked", int'(m_kind), int'(M_LOCKED));

    rst_ni = 1'b0;
    #1; lit("async_reset", 1'b0, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Any non-Off escalation encoding also locks from Idle.
    lc_escalate_en_i = 4'b0000;
    @(posedge clk_i); #1;
    lit("esc_invalid", 1'b1, 1'b1);
    lc_escalate_en_i = LC_OFF;
    rst_ni = 1'b0;
    #1; lit("final_reset", 1'b0, 1'b0);
    @(posedge clk_i); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
